// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte image into instruction memory, then releases the core.
// Optional trailing mod-256 checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              init_en,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_we,
    output logic [31:0]       init_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start, core held in reset
    // LOAD  | receiving image bytes and writing words
    // CHECK | waiting for the checksum byte (checksum builds only)
    // DONE  | image good, core released
    // ERR   | checksum mismatch, core held in reset
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd2,
`endif
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic              all_rx;
    logic              start_ok;
    logic              byte_accept;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    assign last_word = ({1'b0, word_idx} == (len_q - LEN_ONE));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        byte_ready  = 1'b0;
        init_en     = 1'b0;
        core_reset  = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        start_ok    = start && (len != '0) &&
                      ((state == IDLE) || (state == DONE) || (state == ERR));
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = LOAD;
            end
            LOAD: begin
                init_en = 1'b1;
                // All words received: the final strobe cycle takes no more bytes.
                byte_ready = !all_rx;
                if (all_rx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                init_en    = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = (byte_data == sum_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
                if (start_ok) state_nxt = LOAD;
            end
            ERR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                err = 1'b1;
`endif
                if (start_ok) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign byte_accept = byte_valid && byte_ready && (state == LOAD);

    always_ff @(posedge CLK) begin
        if (reset) begin
            len_q      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            all_rx     <= 1'b0;
            init_we    <= 1'b0;
            init_addr  <= '0;
            init_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            init_we <= 1'b0;
            if (start_ok) begin
                len_q    <= len;
                word_idx <= '0;
                byte_idx <= '0;
                all_rx   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q    <= '0;
`endif
            end else if (byte_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q <= sum_q + byte_data;
`endif
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: asm_q[7:0]   <= byte_data;
                    2'd1: asm_q[15:8]  <= byte_data;
                    2'd2: asm_q[23:16] <= byte_data;
                    default: begin
                        init_we    <= 1'b1;
                        init_addr  <= word_idx;
                        init_wdata <= {byte_data, asm_q};
                        // Index stops at len-1 so a full 256-word image never wraps.
                        if (last_word) begin
                            all_rx <= 1'b1;
                        end else begin
                            word_idx <= word_idx + ADDR_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected words/addresses come from hand-built queues.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_imem_loader;

    logic        CLK;
    logic        reset;
    logic        start;
    logic [8:0]  len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        init_en;
    logic [7:0]  init_addr;
    logic        init_we;
    logic [31:0] init_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_waits  = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  csum;

    imem_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .reset(reset), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .init_en(init_en), .init_addr(init_addr), .init_we(init_we),
        .init_wdata(init_wdata), .core_reset(core_reset), .done(done), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [8:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 9'd3;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            tick();
            n++;
            n_waits++;
        end
        if (n >= 100) check_val("ready_timeout", 32'd0, 32'd1);
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic push_word(input logic [7:0] a, input logic [31:0] d);
        exp_addr.push_back(32'(a));
        exp_data.push_back(d);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            csum = csum + w[8*k +: 8];
        end
    endtask

    task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs);
`else
        if (cs == 8'hFF) n_waits = n_waits + 0;
        tick();
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check_val({tag, "_init_en"}, 32'(init_en), 32'd0);
        check_val({tag, "_addr"}, 32'(init_addr), 32'd0);
        check_val({tag, "_we"}, 32'(init_we), 32'd0);
        check_val({tag, "_wdata"}, init_wdata, 32'd0);
        check_val({tag, "_core_rst"}, 32'(core_reset), 32'd1);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (init_we) begin
            n_wr++;
            if (exp_addr.size() == 0) begin
                check_val("extra_we", 32'd1, 32'd0);
            end else begin
                check_val("wr_addr", 32'(init_addr), exp_addr.pop_front());
                check_val("wr_data", init_wdata, exp_data.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = 9'd0;
        byte_valid = 1'b0; byte_data = 8'h00; csum = 8'h00;
        tick(); tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // len=0 ignored, bytes in IDLE dropped
        do_start(9'd0);
        check_val("len0_ready", 32'(byte_ready), 32'd0);
        check_val("len0_init_en", 32'(init_en), 32'd0);
        byte_valid = 1'b1; byte_data = 8'h55;
        tick(); tick();
        byte_valid = 1'b0;
        check_val("idle_ready", 32'(byte_ready), 32'd0);

        // single word 0x13
        do_start(9'd1);
        check_val("ld_init_en", 32'(init_en), 32'd1);
        check_val("ld_core_rst", 32'(core_reset), 32'd1);
        check_val("ld_ready", 32'(byte_ready), 32'd1);
        push_word(8'd0, 32'h0000_0013);
        csum = 8'h00;
        send_word(32'h0000_0013);
        check_val("s1_we", 32'(init_we), 32'd1);
        check_val("s1_addr", 32'(init_addr), 32'd0);
        check_val("s1_wdata", init_wdata, 32'h0000_0013);
        check_val("s1_ready_last", 32'(byte_ready), 32'd0);
        finish_load(csum);
        check_val("s1_done", 32'(done), 32'd1);
        check_val("s1_core_rst", 32'(core_reset), 32'd0);
        check_val("s1_init_en", 32'(init_en), 32'd0);
        check_val("s1_we_off", 32'(init_we), 32'd0);
        check_val("s1_ready_done", 32'(byte_ready), 32'd0);
        check_val("s1_nwr", 32'(n_wr), 32'd1);

        // full 256-word image, back-to-back
        n_wr = 0; n_waits = 0; csum = 8'h00;
        do_start(9'd256);
        check_val("f_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 256; i++) push_word(8'(i), 32'(i));
        for (int i = 0; i < 256; i++) send_word(32'(i));
        check_val("f_waits", 32'(n_waits), 32'd0);
        check_val("f_last_addr", 32'(init_addr), 32'd255);
        finish_load(csum);
        check_val("f_nwr", 32'(n_wr), 32'd256);
        check_val("f_done", 32'(done), 32'd1);
        check_val("f_pending", 32'(exp_addr.size()), 32'd0);

        // len=2 with gaps and an ignored mid-load start
        n_wr = 0; csum = 8'h00;
        do_start(9'd2);
        push_word(8'd0, 32'h4433_2211);
        push_word(8'd1, 32'h8877_6655);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                byte_valid = 1'b0; byte_data = 8'hEE;
                tick();
            end
            if (i == 2) begin
                start = 1'b1; len = 9'd1;
                tick();
                start = 1'b0; len = 9'd3;
            end
            send_byte(8'(8'h11 * (i + 1)));
            csum = csum + 8'(8'h11 * (i + 1));
            byte_valid = 1'b0;
            tick();
        end
        finish_load(csum);
        check_val("g_nwr", 32'(n_wr), 32'd2);
        check_val("g_done", 32'(done), 32'd1);

        // reset mid-word of a len=4 load
        n_wr = 0;
        do_start(9'd4);
        push_word(8'd0, 32'h0403_0201);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        reset = 1'b1;
        tick();
        check_reset_outputs("mid");
        reset = 1'b0;
        check_val("mid_nwr", 32'(n_wr), 32'd1);
        do_start(9'd1);
        push_word(8'd0, 32'hDDCC_BBAA);
        csum = 8'h00;
        send_word(32'hDDCC_BBAA);
        finish_load(csum);
        check_val("mid_nwr2", 32'(n_wr), 32'd2);
        check_val("mid_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start(9'd1);
        push_word(8'd0, 32'h0403_0201);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        tick();
        check_val("ck_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h0A);
        check_val("ck_done", 32'(done), 32'd1);
        check_val("ck_core_rst", 32'(core_reset), 32'd0);
        check_val("ck_err", 32'(err), 32'd0);
        do_start(9'd1);
        push_word(8'd0, 32'h0403_0201);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_byte(8'h0B);
        check_val("ce_err", 32'(err), 32'd1);
        check_val("ce_core_rst", 32'(core_reset), 32'd1);
        check_val("ce_done", 32'(done), 32'd0);
        check_val("ce_init_en", 32'(init_en), 32'd0);
        check_val("ce_ready", 32'(byte_ready), 32'd0);
`else
        check_val("no_ck_err", 32'(err), 32'd0);
`endif

        check_val("end_pending", 32'(exp_addr.size()), 32'd0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction-memory word-address width (256 words).
REQ-002 SHALL have port: CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle load request.
REQ-005 SHALL have port: len  input  ADDR_W+1  number of 32-bit words to load, 1..256; sampled on accepted start.
REQ-006 SHALL have port: byte_valid  input  1  incoming serial byte valid.
REQ-007 SHALL have port: byte_data  input  8  incoming byte.
REQ-008 SHALL have port: byte_ready  output  1  loader accepts byte; transfer occurs when byte_valid && byte_ready.
REQ-009 SHALL have port: init_en  output  1  memory owned by loader; drives core-side init_en.
REQ-010 SHALL have port: init_addr  output  ADDR_W  word address of current write.
REQ-011 SHALL have port: init_we  output  1  one-cycle word write strobe.
REQ-012 SHALL have port: init_wdata  output  32  word to write.
REQ-013 SHALL have port: core_reset  output  1  held high while loading; released when image is good.
REQ-014 SHALL have port: done  output  1  image loaded, core running.
REQ-015 SHALL have port: err  output  1  checksum failure (0 when CHECKSUM_EN is undefined).

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK (CHECKSUM_EN only), DONE, ERR.
REQ-017 In IDLE, DONE or ERR: start=1 with len!=0 SHALL latch len, clear word counter and byte index, set init_en=1 and core_reset=1, clear done/err, and go to LOAD; start with len==0 SHALL be ignored.
REQ-018 In LOAD: byte_ready=1; each accepted byte k (k=0..3) SHALL go to bits [8k+7:8k] of the assembly register (little-endian).
REQ-019 Acceptance of the 4th byte in cycle N SHALL cause init_we=1 in cycle N+1 only, with init_wdata = assembled word and init_addr = word index; init_addr and init_wdata SHALL hold until the next strobe.
REQ-020 byte_ready SHALL stay 1 during the strobe cycle; a byte accepted then SHALL start the next word with no loss.
REQ-021 Word index SHALL increment after each strobe; it SHALL reach len-1 at most and never wrap (len=256 ends at address 255).
REQ-022 After the strobe for word len-1, the next state SHALL be CHECK if CHECKSUM_EN is defined, else DONE.
REQ-023 start SHALL be ignored in LOAD and CHECK.
REQ-024 In DONE: init_en=0, core_reset=0, done=1, byte_ready=0, init_we=0.
REQ-025 In ERR: init_en=0, core_reset=1, err=1, done=0, byte_ready=0.
REQ-026 byte_ready SHALL be 0 in IDLE, DONE and ERR; bytes presented there SHALL be dropped.

Reset
REQ-027 reset=1 SHALL force state IDLE, byte_ready=0, init_en=0, init_addr=0, init_we=0, init_wdata=0, core_reset=1, done=0, err=0, byte index, word counter and checksum cleared, at the next edge, from any state including mid-word and mid-strobe.
REQ-028 reset SHALL take priority over start and byte_valid in the same cycle.

Configuration
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN SHALL, when defined: accumulate an 8-bit modulo-256 sum of all image bytes; in CHECK set byte_ready=1 and accept one byte; equal to sum -> DONE, otherwise -> ERR.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN: no CHECK state or sum logic; err SHALL be constant 0; LOAD goes directly to DONE.

Verification
REQ-031 len=1, bytes 13 00 00 00 -> one init_we cycle, init_addr=0, init_wdata=0x00000013; next cycle done=1, core_reset=0, init_en=0 (macro off).
REQ-032 len=256, 1024 back-to-back bytes (word i = i) -> 256 strobes, addresses 0..255 in order, data matches, no wrap, then done=1.
REQ-033 len=2 with byte_valid toggling 1/0 and random gaps -> same two words at addrs 0,1; no duplicate or dropped bytes.
REQ-034 reset pulsed after 6 bytes of len=4 load -> next cycle all outputs at reset values; new start loads from addr 0 with byte index 0.
REQ-035 Macro on, len=1, bytes 01 02 03 04 then 0A -> done=1, core_reset=0; repeat with 0B -> err=1, core_reset=1, done=0.
REQ-036 start with len=0 -> remains IDLE, byte_ready=0; start pulsed mid-LOAD -> ignored, address sequence unchanged.
